// File: rtl/sisc_pkg.sv
// sisc_pkg: shared opcodes, IR field positions and fetch FSM encodings
package sisc_pkg;
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int MM_MSB  = 27;
  localparam int MM_LSB  = 24;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_LD   = 4'd1,
    OP_ST   = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_SHL  = 4'd9,
    OP_SHR  = 4'd10,
    OP_ROT  = 4'd11,
    OP_BRA  = 4'd12,
    OP_CMP  = 4'd13,
    OP_JMP  = 4'd14,
    OP_HLT  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_INC = 2'd0,
    PC_REL = 2'd1,
    PC_ABS = 2'd2
  } pc_sel_e;
endpackage

// File: rtl/sisc_pc_next.sv
// sisc_pc_next: next-PC selection between increment, relative and absolute targets
module sisc_pc_next import sisc_pkg::*; #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] pc_i,
  input  logic [15:0]   imm_i,
  input  logic [AW-1:0] abs_i,
  input  pc_sel_e       sel_i,
  output logic [AW-1:0] pc_o
);
  logic [AW-1:0] off;
  assign off  = AW'($signed(imm_i));
  assign pc_o = sel_i == PC_ABS ? abs_i : pc_i + (sel_i == PC_REL ? off : AW'(1));
endmodule

// File: rtl/sisc_fetch_unit.sv
// sisc_fetch_unit: PC, IR and status ownership with a req/ack instruction fetch FSM
module sisc_fetch_unit import sisc_pkg::*; #(
  parameter int AW = 16,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_start,
  input  logic          pc_write,
  input  logic          br_sel,
  input  logic          stat_en,
  input  logic [3:0]    alu_stat,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] ir,
  output logic [3:0]    opcode,
  output logic [3:0]    mm,
  output logic [3:0]    stat,
  output logic [AW-1:0] pc,
  output logic          ir_valid,
  output logic          busy
);
  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q;
  logic [3:0]    stat_q;
  logic          fetch_hit, branch;
  pc_sel_e       pc_sel;

  // fetch FSM state register
  always_ff @(posedge clk)
    state_q <= rst ? ST_IDLE : state_d;

  // fetch FSM next state: only IDLE accepts a start, only REQ accepts an ack
  always_comb begin
    state_d = state_q == ST_IDLE ? (fetch_start ? ST_REQ : ST_IDLE) :
              state_q == ST_REQ  ? (imem_ack ? ST_DONE : ST_REQ) : ST_IDLE;
  end

  // fetch FSM outputs and the load conditions derived from the state
  always_comb begin
    imem_req  = state_q == ST_REQ;
    ir_valid  = state_q == ST_DONE;
    busy      = state_q != ST_IDLE;
    fetch_hit = imem_req && imem_ack;
    branch    = state_q == ST_IDLE && pc_write;
    pc_sel    = fetch_hit ? PC_INC : br_sel ? PC_ABS : PC_REL;
  end

  sisc_pc_next #(.AW(AW)) u_pc_next (
    .pc_i  (pc_q),
    .imm_i (ir_q[IMM_MSB:IMM_LSB]),
    .abs_i (ir_q[AW-1:0]),
    .sel_i (pc_sel),
    .pc_o  (pc_d)
  );

  // architectural registers; stat tracks the ALU whenever strobed, regardless of fetch state
  always_ff @(posedge clk)
    if (rst) begin
      pc_q   <= '0;
      ir_q   <= '0;
      stat_q <= '0;
    end else begin
      if (fetch_hit || branch) pc_q <= pc_d;
      if (fetch_hit) ir_q <= imem_data;
      if (stat_en) stat_q <= alu_stat;
    end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign stat      = stat_q;
  assign opcode    = ir_q[OP_MSB:OP_LSB];
  assign mm        = ir_q[MM_MSB:MM_LSB];
endmodule
